// File: rtl/priority_encoder_active_low_irq.sv
// Active-low request lines -> synchronised, falling-edge captured pending set,
// presented one index at a time (lowest index first) over a valid/ack handshake.
module priority_encoder_active_low_irq #(
    parameter int N           = 8,
    parameter int W           = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [0:N-1] req_n,
    input  logic         ack,
    output logic [W-1:0] code,
    output logic         valid,
    output logic [0:N-1] pending,
    output logic         overrun
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t       state_q, state_d;
    logic [0:N-1] sync_q [SYNC_STAGES];
    logic [0:N-1] sync_d [SYNC_STAGES];
    logic [0:N-1] prev_q, prev_d;
    logic [0:N-1] pending_q, pending_d;
    logic [W-1:0] code_q, code_d;
    logic         overrun_q, overrun_d;
    logic [0:N-1] s_last;
    logic [0:N-1] rise;
    logic [0:N-1] clr_mask;

    always_comb begin
        sync_d[0] = req_n;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign s_last = sync_q[SYNC_STAGES-1];
    assign prev_d = s_last;
    // Edge detector keeps tracking while disabled, so edges seen then are lost for good.
    assign rise   = prev_q & ~s_last & {N{enable}};

    // Set wins over a same-cycle clear; only a rise onto a bit that stays set is an overrun.
    always_comb begin
        pending_d = (pending_q & ~clr_mask) | rise;
        overrun_d = overrun_q | (|(rise & pending_q & ~clr_mask));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '1;
            end
            prev_q    <= '1;
            pending_q <= '0;
            overrun_q <= 1'b0;
            code_q    <= '0;
            state_q   <= IDLE;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            prev_q    <= prev_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            code_q    <= code_d;
            state_q   <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|pending_q) state_d = PRESENT;
            PRESENT: if (ack)        state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Code is only (re)loaded at an IDLE decision, so it is frozen while presented.
    always_comb begin
        code_d   = code_q;
        clr_mask = '0;
        if (state_q == IDLE) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pending_q[i]) code_d = W'(i);
            end
        end else if (ack) begin
            clr_mask[code_q] = 1'b1;
        end
    end

    assign code    = code_q;
    assign valid   = (state_q == PRESENT);
    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_priority_encoder_active_low_irq.sv
// Directed bench for priority_encoder_active_low_irq with hand-computed expectations.
module tb_priority_encoder_active_low_irq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [0:7] req_n;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [0:7] pending;
    logic       overrun;

    int n_checks = 0;
    int n_pass   = 0;

    priority_encoder_active_low_irq #(.N(8), .W(3), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req_n(req_n), .ack(ack),
        .code(code), .valid(valid), .pending(pending), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:7] m(input int i);
        logic [0:7] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!valid && n < 12) begin
            tick();
            n++;
        end
        check(tag, 32'(valid), 1);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        req_n  = '1;
        ack    = 1'b0;
        #1;
        check("rst_valid", 32'(valid), 0);
        check("rst_code", 32'(code), 0);
        check("rst_pend", 32'(pending), 0);
        check("rst_ovr", 32'(overrun), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid || code != 0 || pending != 0 || overrun) begin
                check("idle_quiet", 32'({valid, code, pending, overrun}), 0);
            end
        end
        check("idle_valid", 32'(valid), 0);
        check("idle_pend", 32'(pending), 0);

        // Single request, exact latency
        req_n[5] = 1'b0;
        tick();
        tick();
        check("lat_pend_k1", 32'(pending), 0);
        tick();
        check("lat_pend_k2", 32'(pending), 32'(m(5)));
        check("lat_valid_k2", 32'(valid), 0);
        tick();
        check("lat_valid_k3", 32'(valid), 1);
        check("lat_code_k3", 32'(code), 5);
        ack_pulse();
        check("ack5_valid", 32'(valid), 0);
        check("ack5_pend", 32'(pending), 0);
        repeat (5) tick();
        check("hold_low_valid", 32'(valid), 0);
        check("hold_low_pend", 32'(pending), 0);
        req_n[5] = 1'b1;
        repeat (4) tick();

        // Simultaneous 6,2,0 presented in ascending order
        req_n[6] = 1'b0;
        req_n[2] = 1'b0;
        req_n[0] = 1'b0;
        wait_valid("multi_v0");
        check("multi_code0", 32'(code), 0);
        check("multi_pend", 32'(pending), 32'(m(0) | m(2) | m(6)));
        ack_pulse();
        check("multi_gap0", 32'(valid), 0);
        tick();
        check("multi_v2", 32'(valid), 1);
        check("multi_code2", 32'(code), 2);
        ack_pulse();
        check("multi_gap2", 32'(valid), 0);
        tick();
        check("multi_v6", 32'(valid), 1);
        check("multi_code6", 32'(code), 6);
        ack_pulse();
        check("multi_gap6", 32'(valid), 0);
        check("multi_empty", 32'(pending), 0);
        req_n = '1;
        repeat (4) tick();

        // Higher priority arriving during presentation does not preempt
        req_n[4] = 1'b0;
        wait_valid("pre_v4");
        check("pre_code4", 32'(code), 4);
        req_n[1] = 1'b0;
        repeat (4) tick();
        check("pre_hold4", 32'(code), 4);
        check("pre_pend", 32'(pending), 32'(m(1) | m(4)));
        ack_pulse();
        check("pre_gap", 32'(valid), 0);
        tick();
        check("pre_code1", 32'(code), 1);
        ack_pulse();
        req_n = '1;
        repeat (4) tick();
        check("pre_empty", 32'(pending), 0);

        // Same-cycle ack and rise on 3: set wins, no overrun
        req_n[3] = 1'b0;
        wait_valid("sim_v3");
        check("sim_code3", 32'(code), 3);
        req_n[3] = 1'b1;
        repeat (3) tick();
        req_n[3] = 1'b0;
        tick();
        tick();
        ack_pulse();
        check("sim_valid", 32'(valid), 0);
        check("sim_pend", 32'(pending), 32'(m(3)));
        check("sim_ovr", 32'(overrun), 0);
        tick();
        check("sim_re_v", 32'(valid), 1);
        check("sim_re_code", 32'(code), 3);

        // Second fall on an already pending line: sticky overrun
        req_n[3] = 1'b1;
        repeat (3) tick();
        req_n[3] = 1'b0;
        repeat (4) tick();
        check("ovr_set", 32'(overrun), 1);
        check("ovr_code", 32'(code), 3);
        ack_pulse();
        repeat (3) tick();
        check("ovr_sticky", 32'(overrun), 1);
        check("ovr_pend", 32'(pending), 0);
        req_n = '1;
        repeat (4) tick();

        // Disabled capture is lost for good
        enable   = 1'b0;
        req_n[7] = 1'b0;
        repeat (6) tick();
        check("dis_pend", 32'(pending), 0);
        enable = 1'b1;
        repeat (5) tick();
        check("reen_valid", 32'(valid), 0);
        check("reen_pend", 32'(pending), 0);

        // Async reset mid-presentation
        req_n[6] = 1'b0;
        wait_valid("rst_mid_v");
        check("rst_mid_code", 32'(code), 6);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(valid), 0);
        check("arst_code", 32'(code), 0);
        check("arst_pend", 32'(pending), 0);
        check("arst_ovr", 32'(overrun), 0);
        tick();
        rst_n = 1'b1;

        // Lines held low through reset are captured once after release
        wait_valid("post_v");
        check("post_code6", 32'(code), 6);
        check("post_pend", 32'(pending), 32'(m(6) | m(7)));
        ack_pulse();
        tick();
        check("post_code7", 32'(code), 7);
        ack_pulse();
        repeat (5) tick();
        check("post_empty", 32'(pending), 0);
        check("post_valid", 32'(valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
